uart_probe_gen: RTL and testbench

//  Parametrised wrapper/reset test block: debounced decode of the {payload,cmd} input bus,
//  one-cycle reset-command strobe, programmable prescaler and a multi-mode pattern generator
//  on io_out. Sits in place of the UART core to exercise the wrapper, reset path and bench.

---
 rtl/uart_probe_gen.sv | 188 ++++++++++++++++++
 tb/tb_uart_probe_gen.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/uart_probe_gen.sv
// uart_probe_gen: stand-in for the UART core. Debounces the {payload,cmd} input bus,
// emits a one-cycle reset-command strobe, runs a programmable prescaler and drives a
// multi-mode pattern generator onto io_out.
module uart_probe_gen #(
  parameter int                OUT_W      = 8,
  parameter int                PAY_W      = 5,
  parameter int                DIV_W      = 8,
  parameter int                DEBOUNCE   = 2,
  parameter logic [PAY_W-1:0]  RESET_CODE = 5'b11000,
  parameter logic [OUT_W-1:0]  LFSR_TAPS  = 8'hB8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [PAY_W+1:0]   io_in,
  output logic [OUT_W-1:0]   io_out,
  output logic               io_tick,
  output logic               io_resetCommandStrobe,
  output logic               io_gatedTxdStopBitSupport
);

  localparam int         IN_W     = PAY_W + 2;
  localparam logic [3:0] STAB_MAX = 4'(DEBOUNCE);
  localparam logic [3:0] STAB_ACC = 4'(DEBOUNCE - 1);

  localparam logic [1:0] CMD_DATA   = 2'd0;
  localparam logic [1:0] CMD_CONFIG = 2'd1;
  localparam logic [1:0] CMD_PREDIV = 2'd2;

  // Registered state
  logic [IN_W-1:0]  in_q_r;
  logic [3:0]       stab_r;
  logic [2:0]       mode_r;
  logic             run_r;
  logic             stopbit_r;
  logic [DIV_W-1:0] div_reload_r;
  logic [DIV_W-1:0] div_cnt_r;
  logic [OUT_W-1:0] pat_r;
  logic             tick_r;
  logic             strobe_r;

  // Next-state / decode signals
  logic [PAY_W-1:0] payload_s;
  logic [1:0]       cmd_s;
  logic             same_s;
  logic             accept_s;
  logic             adv_s;
  logic [3:0]       stab_nxt_s;
  logic [2:0]       mode_nxt_s;
  logic             run_nxt_s;
  logic             stopbit_nxt_s;
  logic [DIV_W-1:0] div_reload_nxt_s;
  logic [DIV_W-1:0] div_cnt_nxt_s;
  logic [OUT_W-1:0] pat_nxt_s;
  logic             tick_nxt_s;
  logic             strobe_nxt_s;

  // One step of the free-running pattern for the tick-driven modes.
  function automatic logic [OUT_W-1:0] pattern_step(input logic [2:0]       mode,
                                                    input logic [OUT_W-1:0] pat);
    logic [OUT_W-1:0] res;
    case (mode)
      3'd0:    res = pat + OUT_W'(1);
      3'd1:    res = (pat == {OUT_W{1'b0}}) ? OUT_W'(1) : {pat[OUT_W-2:0], pat[OUT_W-1]};
      3'd2: begin
        if (pat == {OUT_W{1'b0}}) begin
          res = OUT_W'(1);
        end else if (pat[0]) begin
          res = (pat >> 1) ^ LFSR_TAPS;
        end else begin
          res = pat >> 1;
        end
      end
      default: res = pat;
    endcase
    return res;
  endfunction

  assign payload_s = io_in[IN_W-1:2];
  assign cmd_s     = io_in[1:0];
  assign same_s    = (io_in == in_q_r);
  assign accept_s  = same_s && (stab_r == STAB_ACC);
  assign adv_s     = run_r && (div_cnt_r == {DIV_W{1'b0}});

  // Debounce counter, command decode, prescaler and pattern next-state.
  always_comb begin
    stab_nxt_s       = stab_r;
    mode_nxt_s       = mode_r;
    run_nxt_s        = run_r;
    stopbit_nxt_s    = stopbit_r;
    div_reload_nxt_s = div_reload_r;
    div_cnt_nxt_s    = div_cnt_r;
    pat_nxt_s        = pat_r;
    tick_nxt_s       = 1'b0;
    strobe_nxt_s     = 1'b0;

    // Stability count saturates so a held value is accepted only once.
    if (same_s) begin
      stab_nxt_s = (stab_r >= STAB_MAX) ? STAB_MAX : stab_r + 4'd1;
    end else begin
      stab_nxt_s = 4'd0;
    end

    // Prescaler: count down, reload and tick on zero; frozen while stopped.
    if (run_r) begin
      if (div_cnt_r != {DIV_W{1'b0}}) begin
        div_cnt_nxt_s = div_cnt_r - DIV_W'(1);
        tick_nxt_s    = 1'b0;
      end else begin
        div_cnt_nxt_s = div_reload_r;
        tick_nxt_s    = 1'b1;
      end
    end else begin
      div_cnt_nxt_s = div_cnt_r;
      tick_nxt_s    = 1'b0;
    end

    // Accepted commands; the reset code pre-empts any configuration change.
    if (accept_s) begin
      case (cmd_s)
        CMD_CONFIG: begin
          if (payload_s == RESET_CODE) begin
            strobe_nxt_s = 1'b1;
          end else begin
            mode_nxt_s    = payload_s[2:0];
            stopbit_nxt_s = payload_s[3];
            run_nxt_s     = payload_s[4];
          end
        end
        CMD_PREDIV: begin
          div_reload_nxt_s = DIV_W'(payload_s);
          div_cnt_nxt_s    = DIV_W'(payload_s);
          tick_nxt_s       = 1'b0;
        end
        default: begin
          strobe_nxt_s = 1'b0;
        end
      endcase
    end else begin
      strobe_nxt_s = 1'b0;
    end

    // Pattern: an accepted DATA/CONFIG/PREDIV owns the edge; otherwise echo or advance.
    if (accept_s && (cmd_s == CMD_DATA)) begin
      pat_nxt_s = OUT_W'(payload_s);
    end else if (accept_s && ((cmd_s == CMD_CONFIG) || (cmd_s == CMD_PREDIV))) begin
      pat_nxt_s = pat_r;
    end else if (mode_r == 3'd3) begin
      pat_nxt_s = OUT_W'(in_q_r);
    end else if (adv_s) begin
      pat_nxt_s = pattern_step(mode_r, pat_r);
    end else begin
      pat_nxt_s = pat_r;
    end
  end

  // State register with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      in_q_r       <= {IN_W{1'b0}};
      stab_r       <= STAB_MAX;
      mode_r       <= 3'd0;
      run_r        <= 1'b1;
      stopbit_r    <= 1'b0;
      div_reload_r <= {DIV_W{1'b1}};
      div_cnt_r    <= {DIV_W{1'b1}};
      pat_r        <= {OUT_W{1'b0}};
      tick_r       <= 1'b0;
      strobe_r     <= 1'b0;
    end else begin
      in_q_r       <= io_in;
      stab_r       <= stab_nxt_s;
      mode_r       <= mode_nxt_s;
      run_r        <= run_nxt_s;
      stopbit_r    <= stopbit_nxt_s;
      div_reload_r <= div_reload_nxt_s;
      div_cnt_r    <= div_cnt_nxt_s;
      pat_r        <= pat_nxt_s;
      tick_r       <= tick_nxt_s;
      strobe_r     <= strobe_nxt_s;
    end
  end

  assign io_out                    = pat_r;
  assign io_tick                   = tick_r;
  assign io_resetCommandStrobe     = strobe_r;
  assign io_gatedTxdStopBitSupport = stopbit_r;

endmodule

// File: tb/tb_uart_probe_gen.sv
// Directed bench for uart_probe_gen with default parameters (DEBOUNCE=2).
module tb_uart_probe_gen;

  logic       clk;
  logic       reset;
  logic [6:0] io_in;
  logic [7:0] io_out;
  logic       io_tick;
  logic       io_resetCommandStrobe;
  logic       io_gatedTxdStopBitSupport;

  int n_checks = 0;
  int n_errors = 0;

  uart_probe_gen dut (
    .clk                       (clk),
    .reset                     (reset),
    .io_in                     (io_in),
    .io_out                    (io_out),
    .io_tick                   (io_tick),
    .io_resetCommandStrobe     (io_resetCommandStrobe),
    .io_gatedTxdStopBitSupport (io_gatedTxdStopBitSupport)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Compare one observed value with its expected value.
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance n clock edges, leaving time 1 unit after the last edge.
  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Present a value and hold it until the accepting (third) edge.
  task automatic apply(input logic [6:0] v);
    io_in = v;
    step(3);
  endtask

  logic [7:0] lfsr_exp [1:5];
  int strobes, ticks, zeros, first_ret, first_tick;

  initial begin
    lfsr_exp[1] = 8'hB8; lfsr_exp[2] = 8'h5C; lfsr_exp[3] = 8'h2E;
    lfsr_exp[4] = 8'h17; lfsr_exp[5] = 8'hB3;
    reset = 1'b1;
    io_in = 7'h00;
    step(1);
    reset = 1'b0;
    chk("rst_out", {24'd0, io_out}, 32'h0);
    chk("rst_tick", {31'd0, io_tick}, 32'h0);
    chk("rst_strobe", {31'd0, io_resetCommandStrobe}, 32'h0);
    chk("rst_gated", {31'd0, io_gatedTxdStopBitSupport}, 32'h0);

    // Test 1: reset-code CONFIG strobes once after the third edge.
    io_in = 7'h61;
    step(2);
    chk("t1_no_early", {31'd0, io_resetCommandStrobe}, 32'h0);
    step(1);
    chk("t1_strobe", {31'd0, io_resetCommandStrobe}, 32'h1);
    strobes = 0;
    for (int i = 0; i < 20; i++) begin
      step(1);
      strobes += int'(io_resetCommandStrobe);
    end
    chk("t1_single", strobes, 32'd0);
    chk("t1_gated", {31'd0, io_gatedTxdStopBitSupport}, 32'h0);
    chk("t1_out", {24'd0, io_out}, 32'h0);

    // Test 2: PREDIV 3 gives a tick every fourth cycle, count mode.
    apply(7'h0E);
    chk("t2_load_tick", {31'd0, io_tick}, 32'h0);
    chk("t2_load_out", {24'd0, io_out}, 32'h0);
    for (int k = 1; k <= 3; k++) begin
      step(3);
      chk("t2_gap", {31'd0, io_tick}, 32'h0);
      step(1);
      chk("t2_tick", {31'd0, io_tick}, 32'h1);
      chk("t2_cnt", {24'd0, io_out}, k);
    end
    apply(7'h01);                    // CONFIG: stop, mode 0
    apply(7'h00);                    // DATA 0
    chk("t2_data0", {24'd0, io_out}, 32'h0);
    apply(7'h02);                    // PREDIV 0
    apply(7'h41);                    // CONFIG: run, mode 0
    chk("t2_cfg_out", {24'd0, io_out}, 32'h0);
    for (int i = 1; i <= 257; i++) begin
      step(1);
      if (i <= 2 || i >= 255) begin
        chk("t2_wrap", {24'd0, io_out}, i % 256);
        chk("t2_every", {31'd0, io_tick}, 32'h1);
      end
    end

    // Test 3: walking one, advancing every cycle.
    apply(7'h05);                    // CONFIG: stop, mode 1
    apply(7'h00);                    // DATA 0
    apply(7'h45);                    // CONFIG: run, mode 1
    for (int j = 0; j <= 8; j++) begin
      step(1);
      chk("t3_walk", {24'd0, io_out}, 32'h1 << (j % 8));
    end

    // Test 4: LFSR from seed 1 has period 255 and never reaches 0.
    apply(7'h09);                    // CONFIG: stop, mode 2
    apply(7'h04);                    // DATA 1
    apply(7'h02);                    // PREDIV 0
    apply(7'h49);                    // CONFIG: run, mode 2
    zeros = 0;
    first_ret = 0;
    for (int s = 1; s <= 255; s++) begin
      step(1);
      if (s <= 5) chk("t4_seq", {24'd0, io_out}, {24'd0, lfsr_exp[s]});
      if (io_out == 8'h00) zeros++;
      if (io_out == 8'h01 && first_ret == 0) first_ret = s;
    end
    chk("t4_zero", zeros, 32'd0);
    chk("t4_period", first_ret, 32'd255);

    // Test 5: glitching input is never accepted; SPARE ignored; stop halts ticks.
    apply(7'h51);                    // CONFIG: run, mode 4 (hold)
    apply(7'h28);                    // DATA 0x0A
    chk("t5_data", {24'd0, io_out}, 32'h0A);
    strobes = 0;
    for (int k = 0; k < 10; k++) begin
      io_in = k[0] ? 7'h04 : 7'h61;
      step(1);
      strobes += int'(io_resetCommandStrobe);
    end
    chk("t5_tog_strobe", strobes, 32'd0);
    chk("t5_tog_out", {24'd0, io_out}, 32'h0A);
    apply(7'h03);
    step(2);
    apply(7'h7F);
    step(2);
    chk("t5_spare_out", {24'd0, io_out}, 32'h0A);
    chk("t5_spare_gated", {31'd0, io_gatedTxdStopBitSupport}, 32'h0);
    chk("t5_spare_tick", {31'd0, io_tick}, 32'h1);
    apply(7'h21);                    // CONFIG: stopbit=1, run=0
    chk("t5_gated", {31'd0, io_gatedTxdStopBitSupport}, 32'h1);
    chk("t5_acc_tick", {31'd0, io_tick}, 32'h1);
    ticks = 0;
    for (int k = 0; k < 6; k++) begin
      step(1);
      ticks += int'(io_tick);
    end
    chk("t5_stopped", ticks, 32'd0);

    // Test 6: reset in the middle of a count.
    apply(7'h09);                    // CONFIG: stop, mode 2
    apply(7'h54);                    // DATA 0x15
    apply(7'h7E);                    // PREDIV 31
    apply(7'h49);                    // CONFIG: run, mode 2
    step(10);
    chk("t6_mid_out", {24'd0, io_out}, 32'h15);
    chk("t6_mid_tick", {31'd0, io_tick}, 32'h0);
    io_in = 7'h61;
    step(1);
    reset = 1'b1;
    io_in = 7'h00;
    step(1);
    chk("t6_rst_out", {24'd0, io_out}, 32'h0);
    chk("t6_rst_tick", {31'd0, io_tick}, 32'h0);
    chk("t6_rst_strobe", {31'd0, io_resetCommandStrobe}, 32'h0);
    reset = 1'b0;
    first_tick = 0;
    for (int n = 1; n <= 300 && first_tick == 0; n++) begin
      step(1);
      if (io_tick) first_tick = n;
    end
    chk("t6_first_tick", first_tick, 32'd256);
    chk("t6_first_out", {24'd0, io_out}, 32'h1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
